// File: rtl/genius_pkg.sv
// Shared types and constants for the genius_engine memory game.
package genius_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_GEN, S_SHOW_ON, S_SHOW_OFF, S_WAIT_IN, S_CHECK, S_WIN, S_LOSE
  } state_e;

  // Fibonacci feedback from bits 16,14,13,11 (1-based) of the 16-bit register
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int ch_w(input int n_ch);
    return $clog2(n_ch);
  endfunction

endpackage

// File: rtl/genius_lfsr.sv
// 16-bit Fibonacci LFSR with synchronous seed load and single-step advance.
module genius_lfsr
  import genius_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [15:0] seed_i,
  output logic [15:0] q_o
);

  logic [15:0] lfsr_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)    lfsr_q <= 16'h0001;
    else if (load_i) lfsr_q <= (seed_i == 16'h0000) ? 16'h0001 : seed_i;
    else if (step_i) lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  end

  assign q_o = lfsr_q;

endmodule

// File: rtl/genius_engine.sv
// Simon-style memory game: random colour sequence, playback, press checking.
// Define GENIUS_SPEEDUP_EN to shorten show/gap times as the level grows.
module genius_engine
  import genius_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int MAX_LEN   = 32,
  parameter int T_SHOW    = 25_000_000,
  parameter int T_GAP     = 12_500_000,
  parameter int T_TIMEOUT = 250_000_000
) (
  input  logic            CLOCK,
  input  logic            reset,
  input  logic            start,
  input  logic [15:0]     seed,
  input  logic [N_CH-1:0] btn,
  output logic [N_CH-1:0] led,
  output logic [6:0]      level,
  output logic            busy,
  output logic            win,
  output logic            lose
);

  localparam int CH_W  = ch_w(N_CH);
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_e          state_q;
  logic [6:0]      level_q, idx_q, lvl_inc_d;
  logic [31:0]     tmr_q, to_q;
  logic [N_CH-1:0] press_q, cur_oh;
  logic [CH_W-1:0] seq_q [MAX_LEN];
  logic [15:0]     lfsr_q;
  logic [1:0]      sh_cur, sh_gen;
  logic            idle_like, lfsr_load, lfsr_step, unused_lfsr;

  assign idle_like = (state_q == S_IDLE) || (state_q == S_WIN) || (state_q == S_LOSE);
  assign lfsr_load = idle_like && start;
  assign lfsr_step = (state_q == S_GEN);
  assign lvl_inc_d = (level_q == 7'(MAX_LEN)) ? level_q : level_q + 7'd1;
  assign unused_lfsr = ^lfsr_q;

  genius_lfsr u_lfsr (
    .clk_i   (CLOCK),
    .rst_n_i (reset),
    .load_i  (lfsr_load),
    .step_i  (lfsr_step),
    .seed_i  (seed),
    .q_o     (lfsr_q)
  );

`ifdef GENIUS_SPEEDUP_EN
  function automatic logic [1:0] spd(input logic [6:0] lvl);
    return (lvl >= 7'd16) ? 2'd2 : (lvl >= 7'd8) ? 2'd1 : 2'd0;
  endfunction
  assign sh_cur = spd(level_q);
  assign sh_gen = spd(lvl_inc_d);
`else
  assign sh_cur = 2'd0;
  assign sh_gen = 2'd0;
`endif

  // A shifted duration can reach 0; hold it at one cycle so the phase still exists.
  function automatic logic [31:0] dur(input logic [31:0] base, input logic [1:0] sh);
    logic [31:0] t;
    t = base >> sh;
    return (t == 32'd0) ? 32'd1 : t;
  endfunction

  always_comb begin
    cur_oh = '0;
    cur_oh[seq_q[idx_q[IDX_W-1:0]]] = 1'b1;
  end

  always_ff @(posedge CLOCK) begin
    if (state_q == S_GEN) seq_q[level_q[IDX_W-1:0]] <= lfsr_q[CH_W-1:0];
  end

  always_ff @(posedge CLOCK or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      level_q <= '0;
      idx_q   <= '0;
      tmr_q   <= '0;
      to_q    <= '0;
      press_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_WIN, S_LOSE: if (start) begin
          level_q <= '0;
          idx_q   <= '0;
          state_q <= S_GEN;
        end
        S_GEN: begin
          level_q <= lvl_inc_d;
          idx_q   <= '0;
          tmr_q   <= dur(32'(T_SHOW), sh_gen) - 32'd1;
          state_q <= S_SHOW_ON;
        end
        S_SHOW_ON: if (tmr_q == 32'd0) begin
          tmr_q   <= dur(32'(T_GAP), sh_cur) - 32'd1;
          state_q <= S_SHOW_OFF;
        end else tmr_q <= tmr_q - 32'd1;
        S_SHOW_OFF: if (tmr_q != 32'd0) tmr_q <= tmr_q - 32'd1;
        else if (idx_q + 7'd1 == level_q) begin
          idx_q   <= '0;
          to_q    <= 32'(T_TIMEOUT - 1);
          state_q <= S_WAIT_IN;
        end else begin
          idx_q   <= idx_q + 7'd1;
          tmr_q   <= dur(32'(T_SHOW), sh_cur) - 32'd1;
          state_q <= S_SHOW_ON;
        end
        // A press on the expiry cycle wins over the timeout.
        S_WAIT_IN: if (btn != '0) begin
          press_q <= btn;
          state_q <= S_CHECK;
        end else if (to_q == 32'd0) state_q <= S_LOSE;
        else to_q <= to_q - 32'd1;
        // Matching the one-hot expected colour also rejects multi-bit presses.
        S_CHECK: if (press_q != cur_oh) state_q <= S_LOSE;
        else if (idx_q + 7'd1 < level_q) begin
          idx_q   <= idx_q + 7'd1;
          to_q    <= 32'(T_TIMEOUT - 1);
          state_q <= S_WAIT_IN;
        end else state_q <= (level_q == 7'(MAX_LEN)) ? S_WIN : S_GEN;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    led = '0;
    case (state_q)
      S_SHOW_ON: led = cur_oh;
      S_CHECK:   led = press_q;
      S_WIN:     led = '1;
      default:   led = '0;
    endcase
  end

  assign level = level_q;
  assign busy  = !idle_like;
  assign win   = (state_q == S_WIN);
  assign lose  = (state_q == S_LOSE);

endmodule
